// File: rtl/decode_stage_if.sv
// Handshake and bundle signals between the fetch side, the decode stage and the
// issue side. The decode stage connects through the slave modport.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            dec_flush_in;
    logic            dec_ins_valid_in;
    logic            dec_ins_ready_out;
    logic [31:0]     dec_ins_in;
    logic [XLEN-1:0] dec_pc_in;
    logic            dec_valid_out;
    logic            dec_ready_in;
    logic [XLEN-1:0] dec_pc_out;
    logic [4:0]      dec_gpr_src_a_out;
    logic [4:0]      dec_gpr_src_b_out;
    logic [4:0]      dec_gpr_dst_out;
    logic            dec_src_a_en_out;
    logic            dec_src_b_en_out;
    logic            dec_dst_en_out;
    logic [2:0]      dec_fmt_out;
    logic [XLEN-1:0] dec_imm_out;
    logic [6:0]      dec_opcode_out;
    logic [2:0]      dec_funct3_out;
    logic [6:0]      dec_funct7_out;
    logic            dec_illegal_out;

    modport slave (
        input  dec_flush_in, dec_ins_valid_in, dec_ins_in, dec_pc_in, dec_ready_in,
        output dec_ins_ready_out, dec_valid_out, dec_pc_out,
               dec_gpr_src_a_out, dec_gpr_src_b_out, dec_gpr_dst_out,
               dec_src_a_en_out, dec_src_b_en_out, dec_dst_en_out,
               dec_fmt_out, dec_imm_out, dec_opcode_out, dec_funct3_out,
               dec_funct7_out, dec_illegal_out
    );

    modport master (
        output dec_flush_in, dec_ins_valid_in, dec_ins_in, dec_pc_in, dec_ready_in,
        input  dec_ins_ready_out, dec_valid_out, dec_pc_out,
               dec_gpr_src_a_out, dec_gpr_src_b_out, dec_gpr_dst_out,
               dec_src_a_en_out, dec_src_b_en_out, dec_dst_en_out,
               dec_fmt_out, dec_imm_out, dec_opcode_out, dec_funct3_out,
               dec_funct7_out, dec_illegal_out
    );
endinterface

// File: rtl/decode_stage.sv
// RISC-V instruction decode stage: combinational field/immediate decode feeding an
// output register backed by one skid entry, so upstream ready comes from a flop.
//
//   state | meaning
//   EMPTY | no bundle held, output invalid
//   ONE   | bundle in output register, skid empty
//   TWO   | output register and skid entry both full, upstream stalled
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit RV32E_EN = 1'b0
) (
    input  logic          dec_clk_in,
    input  logic          dec_rst_n_in,
    decode_stage_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      src_a;
        logic [4:0]      src_b;
        logic [4:0]      dst;
        logic            src_a_en;
        logic            src_b_en;
        logic            dst_en;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } bundle_t;

    state_t      state_q, state_d;
    bundle_t     out_q, out_d;
    bundle_t     skid_q, skid_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    bundle_t     dec;
    logic [31:0] ins;
    logic [31:0] imm32;
    logic        accept;
    logic        consume;

    assign ins     = bus.dec_ins_in;
    assign accept  = bus.dec_ins_valid_in && ready_q;
    assign consume = valid_q && bus.dec_ready_in;

    always_comb begin
        dec        = '0;
        imm32      = '0;
        dec.pc     = bus.dec_pc_in;
        dec.src_a  = ins[19:15];
        dec.src_b  = ins[24:20];
        dec.dst    = ins[11:7];
        dec.opcode = ins[6:0];
        dec.funct3 = ins[14:12];
        dec.funct7 = ins[31:25];

        // Compressed or otherwise non-32-bit encodings never reach a legal format.
        if (ins[1:0] != 2'b11) begin
            dec.fmt = FMT_ILL;
        end else begin
            case (ins[6:0])
                7'b0110011:                                  dec.fmt = FMT_R;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.fmt = FMT_I;
                7'b0100011:                                  dec.fmt = FMT_S;
                7'b1100011:                                  dec.fmt = FMT_B;
                7'b0110111, 7'b0010111:                      dec.fmt = FMT_U;
                7'b1101111:                                  dec.fmt = FMT_J;
                default:                                     dec.fmt = FMT_ILL;
            endcase
        end

        case (dec.fmt)
            FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm32 = {ins[31:12], 12'b0};
            FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm = XLEN'($signed(imm32));

        dec.src_a_en = dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        dec.src_b_en = dec.fmt inside {FMT_R, FMT_S, FMT_B};
        dec.dst_en   = dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};

        dec.illegal = (dec.fmt == FMT_ILL) ||
                      (RV32E_EN && ((dec.src_a_en && dec.src_a[4]) ||
                                    (dec.src_b_en && dec.src_b[4]) ||
                                    (dec.dst_en   && dec.dst[4])));
    end

    always_ff @(posedge dec_clk_in or negedge dec_rst_n_in) begin
        if (!dec_rst_n_in) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (bus.dec_flush_in) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_d   = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        out_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        out_d   = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != TWO);
    end

    assign bus.dec_valid_out     = valid_q;
    assign bus.dec_ins_ready_out = ready_q;
    assign bus.dec_pc_out        = out_q.pc;
    assign bus.dec_gpr_src_a_out = out_q.src_a;
    assign bus.dec_gpr_src_b_out = out_q.src_b;
    assign bus.dec_gpr_dst_out   = out_q.dst;
    assign bus.dec_src_a_en_out  = out_q.src_a_en;
    assign bus.dec_src_b_en_out  = out_q.src_b_en;
    assign bus.dec_dst_en_out    = out_q.dst_en;
    assign bus.dec_fmt_out       = out_q.fmt;
    assign bus.dec_imm_out       = out_q.imm;
    assign bus.dec_opcode_out    = out_q.opcode;
    assign bus.dec_funct3_out    = out_q.funct3;
    assign bus.dec_funct7_out    = out_q.funct7;
    assign bus.dec_illegal_out   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 32-bit plain instance and a 64-bit RV32E instance run in
// lockstep against a queue-based reference of the two-entry stage.
module tb_decode_stage;
    logic clk_sys;
    logic rst_b;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage_if #(.XLEN(32)) bus32 ();
    decode_stage_if #(.XLEN(64)) bus64 ();

    decode_stage #(.XLEN(32), .RV32E_EN(1'b0)) u_dut32 (
        .dec_clk_in   (clk_sys),
        .dec_rst_n_in (rst_b),
        .bus          (bus32.slave)
    );

    decode_stage #(.XLEN(64), .RV32E_EN(1'b1)) u_dut64 (
        .dec_clk_in   (clk_sys),
        .dec_rst_n_in (rst_b),
        .bus          (bus64.slave)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  ra, rb, rd;
        logic        ea, eb, ed;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
        logic        ill_e;
    } exp_t;

    exp_t q[$];

    logic [6:0] legal_ops [10];
    initial legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] w, input logic [63:0] pc);
        exp_t   e;
        longint s;
        s     = longint'($signed(w));
        e.pc  = pc;
        e.ra  = w[19:15];
        e.rb  = w[24:20];
        e.rd  = w[11:7];
        e.op  = w[6:0];
        e.f3  = w[14:12];
        e.f7  = w[31:25];
        if (w[1:0] != 2'b11) e.fmt = 3'd7;
        else begin
            case (w[6:0])
                7'h33:                      e.fmt = 3'd0;
                7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
                7'h23:                      e.fmt = 3'd2;
                7'h63:                      e.fmt = 3'd3;
                7'h37, 7'h17:               e.fmt = 3'd4;
                7'h6F:                      e.fmt = 3'd5;
                default:                    e.fmt = 3'd7;
            endcase
        end
        case (e.fmt)
            3'd1: e.imm = 64'(s >>> 20);
            3'd2: e.imm = 64'(((s >>> 25) <<< 5) | longint'(w[11:7]));
            3'd3: e.imm = 64'(((s >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                              (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1));
            3'd4: e.imm = 64'((s >>> 12) <<< 12);
            3'd5: e.imm = 64'(((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                              (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1));
            default: e.imm = 64'd0;
        endcase
        e.ea    = (e.fmt <= 3'd3);
        e.eb    = (e.fmt == 3'd0) || (e.fmt == 3'd2) || (e.fmt == 3'd3);
        e.ed    = (e.fmt == 3'd0) || (e.fmt == 3'd1) || (e.fmt == 3'd4) || (e.fmt == 3'd5);
        e.ill   = (e.fmt == 3'd7);
        e.ill_e = e.ill || (e.ea && e.ra[4]) || (e.eb && e.rb[4]) || (e.ed && e.rd[4]);
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        bit   ev;
        ev = (q.size() != 0);
        check("valid32", bus32.dec_valid_out, ev);
        check("ready32", bus32.dec_ins_ready_out, q.size() < 2);
        check("valid64", bus64.dec_valid_out, ev);
        check("ready64", bus64.dec_ins_ready_out, q.size() < 2);
        if (ev) begin
            e = q[0];
            check("pc32",     bus32.dec_pc_out, e.pc[31:0]);
            check("src_a",    bus32.dec_gpr_src_a_out, e.ra);
            check("src_b",    bus32.dec_gpr_src_b_out, e.rb);
            check("dst",      bus32.dec_gpr_dst_out, e.rd);
            check("src_a_en", bus32.dec_src_a_en_out, e.ea);
            check("src_b_en", bus32.dec_src_b_en_out, e.eb);
            check("dst_en",   bus32.dec_dst_en_out, e.ed);
            check("fmt32",    bus32.dec_fmt_out, e.fmt);
            check("imm32",    bus32.dec_imm_out, e.imm[31:0]);
            check("opcode",   bus32.dec_opcode_out, e.op);
            check("funct3",   bus32.dec_funct3_out, e.f3);
            check("funct7",   bus32.dec_funct7_out, e.f7);
            check("illegal32", bus32.dec_illegal_out, e.ill);
            check("pc64",     bus64.dec_pc_out, e.pc);
            check("fmt64",    bus64.dec_fmt_out, e.fmt);
            check("imm64",    bus64.dec_imm_out, e.imm);
            check("illegal64e", bus64.dec_illegal_out, e.ill_e);
        end
    endtask

    task automatic drive(input bit fl, input bit v, input logic [31:0] w,
                         input logic [63:0] pc, input bit rdy);
        bus32.dec_flush_in     = fl;
        bus32.dec_ins_valid_in = v;
        bus32.dec_ins_in       = w;
        bus32.dec_pc_in        = pc[31:0];
        bus32.dec_ready_in     = rdy;
        bus64.dec_flush_in     = fl;
        bus64.dec_ins_valid_in = v;
        bus64.dec_ins_in       = w;
        bus64.dec_pc_in        = pc;
        bus64.dec_ready_in     = rdy;
    endtask

    // Called just after a falling edge; applies inputs, advances the reference, checks.
    task automatic step(input bit fl, input bit v, input logic [31:0] w,
                        input logic [63:0] pc, input bit rdy);
        bit acc;
        bit con;
        drive(fl, v, w, pc, rdy);
        acc = v && (q.size() < 2);
        con = (q.size() != 0) && rdy;
        if (fl) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(w, pc));
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        compare_all();
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] pc;
        rst_b = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
        repeat (2) @(negedge clk_sys);
        compare_all();
        check("rst_fmt", bus32.dec_fmt_out, 3'd0);
        check("rst_illegal", bus32.dec_illegal_out, 1'b0);
        rst_b = 1'b1;

        // addi x5,x5,10
        step(1'b0, 1'b1, 32'h00A28293, 64'h1000, 1'b1);
        check("addi_fmt", bus32.dec_fmt_out, 3'd1);
        check("addi_src_a", bus32.dec_gpr_src_a_out, 5'd5);
        check("addi_dst", bus32.dec_gpr_dst_out, 5'd5);
        check("addi_imm", bus32.dec_imm_out, 32'd10);
        check("addi_src_b_en", bus32.dec_src_b_en_out, 1'b0);
        // beq x0,x0,-16 accepted while addi is consumed
        step(1'b0, 1'b1, 32'hFE0008E3, 64'h1004, 1'b1);
        check("beq_fmt", bus32.dec_fmt_out, 3'd3);
        check("beq_imm32", bus32.dec_imm_out, 32'hFFFF_FFF0);
        check("beq_imm64", bus64.dec_imm_out, 64'hFFFF_FFFF_FFFF_FFF0);
        check("beq_dst_en", bus32.dec_dst_en_out, 1'b0);
        step(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);

        // illegal word, then RV32E high-register case
        step(1'b0, 1'b1, 32'h00000000, 64'h2000, 1'b1);
        check("zero_fmt", bus32.dec_fmt_out, 3'd7);
        check("zero_illegal", bus32.dec_illegal_out, 1'b1);
        step(1'b0, 1'b1, 32'h01000033, 64'h2004, 1'b1);
        check("rv32e_illegal", bus64.dec_illegal_out, 1'b1);
        check("rv32i_legal", bus32.dec_illegal_out, 1'b0);
        step(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);

        // back-to-back with downstream stalled, then drain
        step(1'b0, 1'b1, 32'h00100093, 64'h3000, 1'b0);
        step(1'b0, 1'b1, 32'h00200113, 64'h3004, 1'b0);
        check("stall_ready", bus32.dec_ins_ready_out, 1'b0);
        step(1'b0, 1'b1, 32'h00300193, 64'h3008, 1'b0);
        check("stall_hold_pc", bus32.dec_pc_out, 32'h3000);
        step(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        check("drain_pc", bus32.dec_pc_out, 32'h3004);
        step(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);

        // flush while full with an instruction on offer
        step(1'b0, 1'b1, 32'h00400213, 64'h4000, 1'b0);
        step(1'b0, 1'b1, 32'h00500293, 64'h4004, 1'b0);
        step(1'b1, 1'b1, 32'h00600313, 64'h4008, 1'b0);
        check("flush_valid", bus32.dec_valid_out, 1'b0);
        check("flush_ready", bus32.dec_ins_ready_out, 1'b1);
        step(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);

        // reset asserted while full
        step(1'b0, 1'b1, 32'h00700393, 64'h5000, 1'b0);
        step(1'b0, 1'b1, 32'h00800413, 64'h5004, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
        #2 rst_b = 1'b0;
        #1;
        check("arst_valid", bus32.dec_valid_out, 1'b0);
        check("arst_ready", bus32.dec_ins_ready_out, 1'b1);
        check("arst_fmt", bus32.dec_fmt_out, 3'd0);
        check("arst_pc", bus32.dec_pc_out, 32'h0);
        q.delete();
        @(negedge clk_sys);
        rst_b = 1'b1;
        step(1'b0, 1'b1, 32'h00900493, 64'h6000, 1'b0);
        check("post_rst_pc", bus32.dec_pc_out, 32'h6000);

        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = legal_ops[$urandom_range(0, 9)];
            pc = {$urandom, $urandom};
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, w, pc,
                 $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: DECODE_STAGE

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC and immediate; legal values 32 and 64.
REQ-002 Parameter RV32E_EN, default 0; when 1, any used register index with bit 4 set is flagged illegal.
REQ-003 dec_clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 dec_rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 dec_flush_in  input  1  discard all held instructions.
REQ-006 dec_ins_valid_in  input  1  upstream instruction valid.
REQ-007 dec_ins_ready_out  output  1  stage can accept an instruction.
REQ-008 dec_ins_in  input  32  instruction word.
REQ-009 dec_pc_in  input  XLEN  instruction address.
REQ-010 dec_valid_out  output  1  decoded bundle valid.
REQ-011 dec_ready_in  input  1  downstream accepts the bundle.
REQ-012 dec_pc_out  output  XLEN  PC of the presented bundle.
REQ-013 dec_gpr_src_a_out, dec_gpr_src_b_out, dec_gpr_dst_out  output  5 each  ins[19:15], ins[24:20], ins[11:7].
REQ-014 dec_src_a_en_out, dec_src_b_en_out, dec_dst_en_out  output  1 each  field is used by the format.
REQ-015 dec_fmt_out  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-016 dec_imm_out  output  XLEN  sign-extended immediate.
REQ-017 dec_opcode_out  output  7 / dec_funct3_out  output  3 / dec_funct7_out  output  7  raw fields.
REQ-018 dec_illegal_out  output  1  bundle is illegal.

Function
REQ-019 Decode SHALL be combinational on dec_ins_in and registered into the output stage, giving 1-cycle latency from accept to dec_valid_out.
REQ-020 Accept occurs when dec_ins_valid_in and dec_ins_ready_out are both 1; present/consume occurs when dec_valid_out and dec_ready_in are both 1.
REQ-021 Storage: output register plus one skid entry; dec_ins_ready_out SHALL be driven from a register and be 1 exactly when the skid entry is empty.
REQ-022 State: EMPTY (no entries), ONE (output only), TWO (output and skid). EMPTY->ONE on accept. ONE->EMPTY on consume with no accept. ONE->TWO on accept without consume. TWO->ONE on consume; the skid entry moves to the output register.
REQ-023 In ONE, simultaneous accept and consume SHALL load the new bundle into the output register and remain in ONE.
REQ-024 While dec_valid_out=1 and dec_ready_in=0, all bundle outputs SHALL hold stable.
REQ-025 Format by opcode: 0110011=R; 0010011/0000011/1100111/1110011=I; 0100011=S; 1100011=B; 0110111/0010111=U; 1101111=J. Any other opcode, or ins[1:0]!=2'b11, SHALL give illegal.
REQ-026 Field-use enables by format:
 - src_a: R, I, S, B.
 - src_b: R, S, B.
 - dst: R, I, U, J.
 - illegal format: all three enables 0.
REQ-027 Immediate by format:
 - I = ins[31:20].
 - S = {ins[31:25], ins[11:7]}.
 - B = {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
 - U = {ins[31:12], 12'b0}.
 - J = {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
 - All of the above are sign-extended from ins[31] to XLEN.
 - R and illegal formats: imm = 0.
REQ-028 dec_illegal_out=1 SHALL hold when the format is illegal, or when RV32E_EN=1 and an enabled register field has bit 4 set.
REQ-029 dec_flush_in=1 SHALL empty both entries at the next edge, giving dec_valid_out=0 and dec_ins_ready_out=1. Flush overrides any same-cycle accept; the instruction offered that cycle is dropped.

Reset
REQ-030 Reset asserted SHALL immediately force state EMPTY, dec_valid_out=0 and dec_ins_ready_out=1, with all bundle outputs, dec_fmt_out and dec_illegal_out at 0.
REQ-031 Reset mid-operation SHALL discard held bundles; the first accept after deassertion behaves as from EMPTY.

Verification
REQ-032 Accept 0x00A28293 (addi x5,x5,10), dec_ready_in=1 -> next cycle: valid=1, fmt=1, src_a=5, dst=5, imm=10, src_b_en=0.
REQ-033 Accept 0xFE0008E3 (beq x0,x0,-16) -> fmt=3, imm=0xFFFFFFF0 (XLEN=32), dst_en=0.
REQ-034 Hold dec_ready_in=0 and offer 3 instructions back-to-back -> 2 accepted, dec_ins_ready_out=0 from the 3rd cycle, outputs stable. Then release -> bundles delivered in order, no loss or duplicates.
REQ-035 Flush in state TWO with a simultaneous valid input -> next cycle: valid=0, ready=1, offered instruction not delivered.
REQ-036 Instruction 0x00000000 -> fmt=7, illegal=1. With RV32E_EN=1, 0x01000033 (add x0,x0,x16) -> illegal=1.
REQ-037 Assert reset while in TWO -> valid=0 and ready=1 immediately, before any clock edge.
